// File: rtl/result_writer.sv
// result_writer: scatters kernel results into the frame interior, then zero-fills the one-pixel border
module result_writer #(
  parameter int IMG_W = 64,
  parameter int IMG_H = 64,
  parameter int DATA_W = 13,
  parameter int ADDR_W = 12
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic              result,
  input  logic [DATA_W-1:0] output_result,
  output logic              wr_en,
  output logic [ADDR_W-1:0] wr_addr,
  output logic [DATA_W-1:0] wr_data,
  output logic              busy,
  output logic              frame_done,
  output logic              overflow,
  output logic [ADDR_W-1:0] result_count
);
  localparam logic [1:0] IDLE = 2'd0, COLLECT = 2'd1, BORDER = 2'd2, DONE = 2'd3;
  localparam logic [ADDR_W-1:0] ONE = ADDR_W'(1);
  localparam logic [ADDR_W-1:0] W = ADDR_W'(IMG_W);
  localparam logic [ADDR_W-1:0] W1 = ADDR_W'(IMG_W - 1);
  localparam logic [ADDR_W-1:0] COL_MAX = ADDR_W'(IMG_W - 3);
  localparam logic [ADDR_W-1:0] ROW_MAX = ADDR_W'(IMG_H - 3);
  localparam logic [ADDR_W-1:0] B_LAST = ADDR_W'(2 * IMG_W + 2 * (IMG_H - 2) - 1);
  localparam logic [ADDR_W-1:0] BOT_END = ADDR_W'(2 * IMG_W);
  localparam logic [ADDR_W-1:0] BOT_OFF = ADDR_W'((IMG_H - 2) * IMG_W);
  localparam logic [ADDR_W-1:0] LEFT_END = ADDR_W'(2 * IMG_W + IMG_H - 2);
  localparam logic [ADDR_W-1:0] LEFT_OFF = ADDR_W'(2 * IMG_W - 1);
  localparam logic [ADDR_W-1:0] RIGHT_OFF = ADDR_W'(2 * IMG_W + IMG_H - 3);
  logic [1:0] state;
  logic [ADDR_W-1:0] row, col, b, int_addr, b_addr;
  logic wrap, last;
  always_comb begin
    wrap = col == COL_MAX;
    last = wrap && row == ROW_MAX;
    int_addr = (row + ONE) * W + col + ONE;
    b_addr = b < W ? b :
             b < BOT_END ? b + BOT_OFF :
             b < LEFT_END ? (b - LEFT_OFF) * W :
             (b - RIGHT_OFF) * W + W1;
  end
  assign busy = state == COLLECT || state == BORDER;
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
      row <= '0;
      col <= '0;
      b <= '0;
      wr_en <= 1'b0;
      wr_addr <= '0;
      wr_data <= '0;
      frame_done <= 1'b0;
      overflow <= 1'b0;
      result_count <= '0;
    end else begin
      wr_en <= 1'b0;
      frame_done <= 1'b0;
      if (result && state != COLLECT)
        overflow <= 1'b1;
      else if (start && state == IDLE)
        overflow <= 1'b0;
      case (state)
        IDLE: if (start) begin
          state <= COLLECT;
          row <= '0;
          col <= '0;
          b <= '0;
          result_count <= '0;
        end
        COLLECT: if (result) begin
          wr_en <= 1'b1;
          wr_addr <= int_addr;
          wr_data <= output_result;
          result_count <= result_count + ONE;
          col <= wrap ? '0 : col + ONE;
          row <= wrap ? row + ONE : row;
          state <= last ? BORDER : COLLECT;
        end
        BORDER: begin
          wr_en <= 1'b1;
          wr_addr <= b_addr;
          wr_data <= '0;
          b <= b + ONE;
          state <= b == B_LAST ? DONE : BORDER;
        end
        DONE: begin
          frame_done <= 1'b1;
          state <= IDLE;
        end
      endcase
    end
  end
endmodule

// File: tb/tb_result_writer.sv
// tb_result_writer: scoreboard bench for result_writer
module tb_result_writer;
  localparam int W = 64, H = 64, DW = 13, AW = 12, NINT = (W - 2) * (H - 2);
  logic clk = 1'b0;
  logic rst, start, result;
  logic [DW-1:0] output_result;
  logic wr_en, busy, frame_done, overflow;
  logic [AW-1:0] wr_addr, result_count;
  logic [DW-1:0] wr_data;
  typedef struct {
    logic [AW-1:0] a;
    logic [DW-1:0] d;
  } exp_t;
  exp_t q[$];
  bit seen[W*H];
  int distinct = 0;
  int checks = 0, errors = 0, fd_count = 0;
  result_writer #(.IMG_W(W), .IMG_H(H), .DATA_W(DW), .ADDR_W(AW)) dut (
    .clk(clk), .rst(rst), .start(start), .result(result), .output_result(output_result),
    .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data), .busy(busy),
    .frame_done(frame_done), .overflow(overflow), .result_count(result_count)
  );
  always #5 clk = ~clk;
  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask
  task automatic cyc();
    @(posedge clk);
    #1;
  endtask
  always @(negedge clk) begin
    if (frame_done) fd_count++;
    if (wr_en) begin
      if (q.size() == 0) check("spurious_wr_en", 32'(wr_en), 32'd0);
      else begin
        exp_t e;
        e = q.pop_front();
        check("wr_addr", 32'(wr_addr), 32'(e.a));
        check("wr_data", 32'(wr_data), 32'(e.d));
        if (!seen[wr_addr]) begin
          seen[wr_addr] = 1'b1;
          distinct++;
        end
      end
    end
  end
  task automatic push_border();
    for (int c = 0; c < W; c++) q.push_back('{AW'(c), '0});
    for (int c = 0; c < W; c++) q.push_back('{AW'((H - 1) * W + c), '0});
    for (int r = 1; r < H - 1; r++) q.push_back('{AW'(r * W), '0});
    for (int r = 1; r < H - 1; r++) q.push_back('{AW'(r * W + W - 1), '0});
  endtask
  task automatic check_reset_outputs(input string tag);
    check({tag, "_wr_en"}, 32'(wr_en), 32'd0);
    check({tag, "_wr_addr"}, 32'(wr_addr), 32'd0);
    check({tag, "_wr_data"}, 32'(wr_data), 32'd0);
    check({tag, "_busy"}, 32'(busy), 32'd0);
    check({tag, "_frame_done"}, 32'(frame_done), 32'd0);
    check({tag, "_overflow"}, 32'(overflow), 32'd0);
    check({tag, "_result_count"}, 32'(result_count), 32'd0);
  endtask
  task automatic run_frame(input int gap_pct, input bit chk_first, input int abort_at, input bit inject);
    bit got;
    distinct = 0;
    seen = '{default: 1'b0};
    cyc();
    start = 1'b1;
    cyc();
    start = 1'b0;
    check("busy_after_start", 32'(busy), 32'd1);
    check("ovf_clear_on_start", 32'(overflow), 32'd0);
    check("count_cleared", 32'(result_count), 32'd0);
    for (int n = 0; n < NINT; n++) begin
      if (n == abort_at) begin
        rst = 1'b1;
        start = 1'b1;
        result = 1'b1;
        cyc();
        rst = 1'b0;
        start = 1'b0;
        result = 1'b0;
        check("abort_q_drained", 32'(q.size()), 32'd0);
        check_reset_outputs("abort");
        q.delete();
        return;
      end
      while ($urandom_range(99) < gap_pct) begin
        result = 1'b0;
        cyc();
      end
      result = 1'b1;
      output_result = (chk_first && n == 0) ? DW'(13'h1ABC) : DW'($urandom);
      q.push_back('{AW'((n / (W - 2) + 1) * W + n % (W - 2) + 1), output_result});
      if (n == NINT - 1) push_border();
      cyc();
      if (chk_first && n == 0) begin
        check("first_wr_en", 32'(wr_en), 32'd1);
        check("first_wr_addr", 32'(wr_addr), 32'd65);
        check("first_wr_data", 32'(wr_data), 32'h1ABC);
        check("first_count", 32'(result_count), 32'd1);
        check("first_busy", 32'(busy), 32'd1);
      end
    end
    result = 1'b0;
    got = 1'b0;
    for (int i = 0; i < 400; i++) begin
      @(negedge clk);
      if (inject && i == 10) result = 1'b1;
      if (inject && i == 11) result = 1'b0;
      if (frame_done) begin
        got = 1'b1;
        break;
      end
    end
    result = 1'b0;
    check("frame_done_seen", 32'(got), 32'd1);
    check("q_drained", 32'(q.size()), 32'd0);
    check("wr_en_at_done", 32'(wr_en), 32'd0);
    check("busy_at_done", 32'(busy), 32'd0);
    check("distinct_addrs", 32'(distinct), 32'(W * H));
    check("final_count", 32'(result_count), 32'(NINT));
    check("overflow_after_frame", 32'(overflow), 32'(inject));
    @(negedge clk);
    check("frame_done_one_cycle", 32'(frame_done), 32'd0);
  endtask
  initial begin
    int fd0;
    rst = 1'b1;
    start = 1'b0;
    result = 1'b0;
    output_result = '0;
    repeat (3) cyc();
    check_reset_outputs("reset");
    rst = 1'b0;
    run_frame(0, 1'b1, -1, 1'b0);
    run_frame(30, 1'b0, -1, 1'b1);
    cyc();
    result = 1'b1;
    output_result = DW'(13'h0F0F);
    cyc();
    result = 1'b0;
    cyc();
    check("idle_overflow", 32'(overflow), 32'd1);
    check("idle_count_held", 32'(result_count), 32'(NINT));
    check("idle_busy", 32'(busy), 32'd0);
    fd0 = fd_count;
    run_frame(0, 1'b0, 1000, 1'b0);
    repeat (300) cyc();
    check("no_fd_after_abort", 32'(fd_count), 32'(fd0));
    check("idle_after_abort", 32'(busy), 32'd0);
    run_frame(0, 1'b0, -1, 1'b0);
    check("fd_after_restart", 32'(fd_count), 32'(fd0 + 1));
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule

// File: doc/result_writer.md
RESULT_WRITER -- requirements
Module: result_writer

Interface
REQ-001 Parameter IMG_W, default 64, frame width in pixels.
REQ-002 Parameter IMG_H, default 64, frame height in pixels.
REQ-003 Parameter DATA_W, default 13, width of a kernel result word.
REQ-004 Parameter ADDR_W, default 12, width of the output frame address (log2 of IMG_W*IMG_H).
REQ-005 clk  input  1  the single clock; all state SHALL update on its rising edge.
REQ-006 rst  input  1  synchronous, active-high reset.
REQ-007 start  input  1  one-cycle pulse that arms collection of one frame.
REQ-008 result  input  1  valid strobe from the upstream kernel stage; one result per asserted cycle.
REQ-009 output_result  input  DATA_W  kernel result word, qualified by result.
REQ-010 wr_en  output  1  output-frame RAM write enable.
REQ-011 wr_addr  output  ADDR_W  output-frame RAM write address, row-major (row*IMG_W+col).
REQ-012 wr_data  output  DATA_W  output-frame RAM write data.
REQ-013 busy  output  1  high in COLLECT and BORDER.
REQ-014 frame_done  output  1  one-cycle pulse when the frame is completely written.
REQ-015 overflow  output  1  sticky flag: a result arrived while not in COLLECT.
REQ-016 result_count  output  ADDR_W  number of results accepted in the current frame.

Function
REQ-017 FSM states SHALL be IDLE, COLLECT, BORDER and DONE.
REQ-018 IDLE->COLLECT on start; start in any other state SHALL be ignored.
REQ-019 In COLLECT, each result=1 SHALL produce exactly one write on the next cycle: wr_en=1, wr_data=output_result, wr_addr=(row+1)*IMG_W+(col+1).
REQ-020 col SHALL run 0..IMG_W-3; at IMG_W-3 it wraps to 0 and row increments; row SHALL run 0..IMG_H-3.
REQ-021 result_count SHALL increment by one per accepted result; it holds (not reset) through BORDER, DONE and IDLE until the next start clears it.
REQ-022 Acceptance of the (IMG_W-2)*(IMG_H-2)th result (3844 at defaults) SHALL move COLLECT->BORDER on the same edge.
REQ-023 BORDER SHALL issue 2*IMG_W+2*(IMG_H-2) writes (252 at defaults), one per cycle, wr_data=0, border index b in order:
  - b<IMG_W: addr=b (top row)
  - b<2*IMG_W: addr=(IMG_H-1)*IMG_W+(b-IMG_W) (bottom row)
  - next IMG_H-2: addr=(b-2*IMG_W+1)*IMG_W (left column, rows 1..IMG_H-2)
  - last IMG_H-2: addr=(b-2*IMG_W-IMG_H+3)*IMG_W+IMG_W-1 (right column).
REQ-024 The first border write SHALL occur on the cycle immediately after the last interior write, with no gap.
REQ-025 After the last border write BORDER->DONE; DONE SHALL assert frame_done for exactly one cycle, then go to IDLE.
REQ-026 wr_en SHALL be 0 in IDLE and DONE, and in COLLECT on any cycle following result=0.
REQ-027 result=1 in IDLE, BORDER or DONE SHALL be dropped (no write, no count change) and SHALL set overflow.
REQ-028 overflow SHALL clear only on rst or on start.
REQ-029 Address arithmetic SHALL be computed at ADDR_W bits with no truncation at default parameters.

Reset
REQ-030 rst=1 SHALL force IDLE on the next edge with wr_en=0, wr_addr=0, wr_data=0, busy=0, frame_done=0, overflow=0, result_count=0, row=col=b=0.
REQ-031 rst SHALL take priority over start and result on the same cycle.
REQ-032 rst mid-COLLECT or mid-BORDER SHALL abandon the frame; no further writes and no frame_done until a new start completes a frame.

Verification
REQ-033 Reset, start, one result 0x1ABC -> next cycle wr_en=1, wr_addr=65, wr_data=0x1ABC, result_count=1, busy=1.
REQ-034 Results 62 and 63 of a frame -> wr_addr=126 then 129 (row wrap).
REQ-035 Full frame of 3844 back-to-back results -> last interior wr_addr=4030; then 252 consecutive zero writes, first addr 0, addrs 64, 127 and 3968 included, last addr 4031; frame_done one cycle later, then busy=0; 4096 distinct addresses written in total.
REQ-036 Random gaps in result during COLLECT -> writes only on the cycles following result=1, address sequence identical to REQ-035.
REQ-037 result=1 in IDLE and during BORDER -> no extra write, result_count unchanged, overflow=1 until the next start.
REQ-038 rst asserted at result 1000 -> next cycle all outputs at reset values; subsequent start plus full frame -> normal completion with frame_done.
